// File: rtl/liteeth_sram_pkg.sv
// Shared constants, types and helpers for the liteeth 1rw1r SRAM controller.
package liteeth_sram_pkg;

  localparam int BITS       = 32;
  localparam int WORD_DEPTH = 384;
  localparam int ADDR_WIDTH = 9;
  localparam int MASK_WIDTH = BITS / 8;
  localparam int RSP_DEPTH  = 2;

  typedef enum logic {INIT, RUN} ctrl_state_e;

  typedef struct packed {
    logic [BITS-1:0] rdata;
    logic            err;
  } rsp_t;

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    return addr < ADDR_WIDTH'(WORD_DEPTH);
  endfunction

  function automatic logic [BITS-1:0] merge_bytes(input logic [BITS-1:0]       old_w,
                                                  input logic [BITS-1:0]       new_w,
                                                  input logic [MASK_WIDTH-1:0] mask);
    logic [BITS-1:0] m;
    m = old_w;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (mask[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/liteeth_sram_rsp_buf.sv
// Per-channel read-response buffer: one-cycle capture stage into a small FIFO,
// plus the credit count (inflight + occupancy) that gates request acceptance.
module liteeth_sram_rsp_buf
  import liteeth_sram_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd_accept,
  input  logic            rd_oor,
  input  logic [BITS-1:0] rd_data,
  input  logic            rsp_ready,
  output logic            rsp_valid,
  output logic [BITS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            credit_ok
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  rsp_t           mem_q [RSP_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  occ_q, credit_q;
  logic           pend_q, pend_err_q;
  logic           push, pop;
  rsp_t           push_entry;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = pend_q;
  assign rsp_valid = (occ_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = mem_q[rd_ptr_q].rdata;
  assign rsp_err   = mem_q[rd_ptr_q].err;
  // A pop this cycle frees a slot, so a new read may be taken alongside it.
  assign credit_ok = (credit_q < CW'(RSP_DEPTH)) || pop;

  always_comb begin
    push_entry.rdata = pend_err_q ? '0 : rd_data;
    push_entry.err   = pend_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      credit_q   <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pend_q     <= rd_accept;
      pend_err_q <= rd_oor;
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
      case ({rd_accept, pop})
        2'b10:   credit_q <= credit_q + 1'b1;
        2'b01:   credit_q <= credit_q - 1'b1;
        default: credit_q <= credit_q;
      endcase
    end
  end

endmodule

// File: rtl/liteeth_sram_ctrl.sv
// Initiator for the 1rw1r SRAM macro: zero-fills after reset, then maps channel A
// to rw0 and channel B to r0. Define SRAM_CTRL_WR_FWD_EN to forward same-address A writes into B reads.
//   state | meaning
//   INIT  | zero-fill one word per cycle, both channels blocked
//   RUN   | serve channel A (rw0) and channel B (r0) requests
module liteeth_sram_ctrl
  import liteeth_sram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [BITS-1:0]       a_req_wdata,
  input  logic [MASK_WIDTH-1:0] a_req_wmask,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [BITS-1:0]       a_rsp_rdata,
  output logic                  a_rsp_err,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [BITS-1:0]       b_rsp_rdata,
  output logic                  b_rsp_err,
  output logic                  sram_rw0_ce,
  output logic                  sram_rw0_we,
  output logic [ADDR_WIDTH-1:0] sram_rw0_addr,
  output logic [BITS-1:0]       sram_rw0_wd,
  output logic [MASK_WIDTH-1:0] sram_rw0_wmask,
  input  logic [BITS-1:0]       sram_rw0_rd,
  output logic                  sram_r0_ce,
  output logic [ADDR_WIDTH-1:0] sram_r0_addr,
  input  logic [BITS-1:0]       sram_r0_rd,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  ctrl_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  run;
  logic                  a_credit_ok, b_credit_ok;
  logic                  a_fire, b_fire;
  logic                  a_in_range, b_in_range;
  logic [BITS-1:0]       b_rd_data;

  assign run         = (state_q == RUN);
  assign init_done   = run;
  assign a_in_range  = addr_ok(a_req_addr);
  assign b_in_range  = addr_ok(b_req_addr);
  assign a_req_ready = run && (a_req_we || a_credit_ok);
  assign b_req_ready = run && b_credit_ok;
  assign a_fire      = a_req_valid && a_req_ready;
  assign b_fire      = b_req_valid && b_req_ready;
  assign sram_r0_addr = b_req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    sram_rw0_ce    = 1'b0;
    sram_rw0_we    = 1'b0;
    sram_rw0_addr  = a_req_addr;
    sram_rw0_wd    = a_req_wdata;
    sram_rw0_wmask = a_req_wmask;
    sram_r0_ce     = 1'b0;
    case (state_q)
      INIT: begin
        // Keep the macro idle while reset is held; the fill starts on the first clock after release.
        sram_rw0_ce    = rst_n;
        sram_rw0_we    = rst_n;
        sram_rw0_addr  = init_cnt_q;
        sram_rw0_wd    = '0;
        sram_rw0_wmask = '1;
        if (init_cnt_q == LAST_ADDR) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      RUN: begin
        sram_rw0_ce = a_fire && a_in_range;
        sram_rw0_we = a_fire && a_in_range && a_req_we;
        sram_r0_ce  = b_fire && b_in_range;
      end
      default: state_d = INIT;
    endcase
  end

`ifdef SRAM_CTRL_WR_FWD_EN
  logic                  fwd_hit_q;
  logic [BITS-1:0]       fwd_wdata_q;
  logic [MASK_WIDTH-1:0] fwd_mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q   <= 1'b0;
      fwd_wdata_q <= '0;
      fwd_mask_q  <= '0;
    end else begin
      fwd_hit_q   <= sram_rw0_we && sram_r0_ce && (a_req_addr == b_req_addr);
      fwd_wdata_q <= a_req_wdata;
      fwd_mask_q  <= a_req_wmask;
    end
  end

  assign b_rd_data = fwd_hit_q ? merge_bytes(sram_r0_rd, fwd_wdata_q, fwd_mask_q) : sram_r0_rd;
`else
  assign b_rd_data = sram_r0_rd;
`endif

  liteeth_sram_rsp_buf #(.RSP_DEPTH(RSP_DEPTH)) u_a_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_accept (a_fire && !a_req_we),
    .rd_oor    (!a_in_range),
    .rd_data   (sram_rw0_rd),
    .rsp_ready (a_rsp_ready),
    .rsp_valid (a_rsp_valid),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err),
    .credit_ok (a_credit_ok)
  );

  liteeth_sram_rsp_buf #(.RSP_DEPTH(RSP_DEPTH)) u_b_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_accept (b_fire),
    .rd_oor    (!b_in_range),
    .rd_data   (b_rd_data),
    .rsp_ready (b_rsp_ready),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err),
    .credit_ok (b_credit_ok)
  );

endmodule

// File: tb/tb_liteeth_sram_ctrl.sv
// Directed bench for liteeth_sram_ctrl with a behavioural 1rw1r macro model.
module tb_liteeth_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req_valid = 1'b0, a_req_we = 1'b0;
  logic [8:0]  a_req_addr = '0;
  logic [31:0] a_req_wdata = '0;
  logic [3:0]  a_req_wmask = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic        a_rsp_ready = 1'b1;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid = 1'b0;
  logic [8:0]  b_req_addr = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic        b_rsp_ready = 1'b1;
  logic [31:0] b_rsp_rdata;
  logic        sram_rw0_ce, sram_rw0_we, sram_r0_ce;
  logic [8:0]  sram_rw0_addr, sram_r0_addr;
  logic [31:0] sram_rw0_wd, sram_rw0_rd, sram_r0_rd;
  logic [3:0]  sram_rw0_wmask;
  logic        init_done;

  int n_checks = 0;
  int n_fail = 0;
  logic mon_rw0 = 1'b0;
  int rw0_ce_hits = 0;

  always #5 clk = ~clk;

  liteeth_sram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_wmask(a_req_wmask),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
    .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
    .b_rsp_err(b_rsp_err),
    .sram_rw0_ce(sram_rw0_ce), .sram_rw0_we(sram_rw0_we), .sram_rw0_addr(sram_rw0_addr),
    .sram_rw0_wd(sram_rw0_wd), .sram_rw0_wmask(sram_rw0_wmask), .sram_rw0_rd(sram_rw0_rd),
    .sram_r0_ce(sram_r0_ce), .sram_r0_addr(sram_r0_addr), .sram_r0_rd(sram_r0_rd),
    .init_done(init_done)
  );

  // Macro model: read-first, registered read data, X when not enabled.
  // Contents are reseeded with nonzero garbage during reset so the zero-fill is visible.
  logic [31:0] mem [0:383];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 384; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (sram_rw0_ce && sram_rw0_addr < 9'd384 && sram_rw0_we) begin
      for (int i = 0; i < 4; i++)
        if (sram_rw0_wmask[i]) mem[sram_rw0_addr][8*i +: 8] <= sram_rw0_wd[8*i +: 8];
    end
    sram_rw0_rd <= (sram_rw0_ce && !sram_rw0_we && sram_rw0_addr < 9'd384) ? mem[sram_rw0_addr] : 'x;
    sram_r0_rd  <= (sram_r0_ce && sram_r0_addr < 9'd384) ? mem[sram_r0_addr] : 'x;
  end

  always @(posedge clk) if (mon_rw0 && sram_rw0_ce) rw0_ce_hits++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (n < 1000) begin
      @(posedge clk); #1; n++;
      if (n == 200) begin
        check_eq("init_addr200", 64'(sram_rw0_addr), 64'd200);
        check_eq("init_we_mask", {sram_rw0_ce, sram_rw0_we, sram_rw0_wmask}, 6'b11_1111);
        check_eq("init_ready", {a_req_ready, b_req_ready}, 2'b00);
      end
      if (init_done) break;
    end
  endtask

  task automatic a_xfer(input logic we, input logic [8:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    int n = 0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_wmask = wm;
    #1;
    while (!a_req_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) check_eq("a_req_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
  endtask

  task automatic a_read(input logic [8:0] addr, output logic [31:0] rd, output logic err, output int lat);
    a_xfer(1'b0, addr, 32'h0, 4'h0);
    lat = 1;
    while (!a_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = a_rsp_rdata; err = a_rsp_err;
  endtask

  task automatic b_read(input logic [8:0] addr, output logic [31:0] rd, output logic err, output int lat);
    int n = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_addr = addr;
    #1;
    while (!b_req_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) check_eq("b_req_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = b_rsp_rdata; err = b_rsp_err;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat, acc, ng;
    logic [31:0] rd;
    logic err;
    logic [31:0] got [4];
    logic fire, last_ready;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {a_req_ready, b_req_ready}, 2'b00);
    check_eq("rst_valid", {a_rsp_valid, b_rsp_valid}, 2'b00);
    check_eq("rst_init_done", 64'(init_done), 64'd0);
    check_eq("rst_ce", {sram_rw0_ce, sram_rw0_we, sram_r0_ce}, 3'b000);
    check_eq("rst_rsp", {a_rsp_rdata, a_rsp_err, b_rsp_err}, 34'h0);

    @(negedge clk); rst_n = 1'b1;
    wait_init(n);
    check_eq("init_cycles", 64'(n), 64'd384);

    b_read(9'd0, rd, err, lat);
    check_eq("b_rd0", {rd, err}, {32'h0, 1'b0});
    b_read(9'd200, rd, err, lat);
    check_eq("b_rd200", {rd, err}, {32'h0, 1'b0});
    b_read(9'd383, rd, err, lat);
    check_eq("b_rd383", {rd, err}, {32'h0, 1'b0});
    check_eq("b_lat", 64'(lat), 64'd2);

    // Masked write then readback
    a_xfer(1'b1, 9'd5, 32'hDEAD_BEEF, 4'b0101);
    repeat (3) @(posedge clk);
    #1;
    check_eq("wr_no_rsp", 64'(a_rsp_valid), 64'd0);
    a_read(9'd5, rd, err, lat);
    check_eq("a_rd5", {rd, err}, {32'h00AD_00EF, 1'b0});
    check_eq("a_lat", 64'(lat), 64'd2);
    @(posedge clk); #1;
    check_eq("a_popped", 64'(a_rsp_valid), 64'd0);

    // Backpressure on B: preload 1..4 with distinct words
    for (int i = 1; i <= 4; i++) a_xfer(1'b1, 9'(i), 32'h100 + 32'(i), 4'hF);
    acc = 0; ng = 0; last_ready = 1'b1;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      b_rsp_ready = (c >= 8);
      b_req_valid = (acc < 4);
      b_req_addr  = 9'(acc + 1);
      #1;
      if (c == 7) begin
        check_eq("bp_accepted", 64'(acc), 64'd2);
        check_eq("bp_ready", 64'(b_req_ready), 64'd0);
      end
      fire = b_req_valid && b_req_ready;
      if (b_rsp_valid && b_rsp_ready) begin
        got[ng] = b_rsp_rdata;
        ng++;
      end
      @(posedge clk);
      if (fire) acc++;
    end
    @(negedge clk); b_req_valid = 1'b0;
    check_eq("bp_count", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("bp_order%0d", i), 64'(got[i]), 64'h101 + 64'(i));
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_no_dup", 64'(b_rsp_valid), 64'd0);
    check_eq("bp_ready_back", 64'(last_ready && b_req_ready), 64'd1);

    // Out of range on A, rw0 must stay idle
    mon_rw0 = 1'b1;
    a_read(9'd400, rd, err, lat);
    mon_rw0 = 1'b0;
    check_eq("a_oor", {rd, err}, {32'h0, 1'b1});
    check_eq("a_oor_lat", 64'(lat), 64'd2);
    check_eq("a_oor_ce", 64'(rw0_ce_hits), 64'd0);
    b_read(9'd511, rd, err, lat);
    check_eq("b_oor", {rd, err}, {32'h0, 1'b1});
    a_xfer(1'b1, 9'd383, 32'hCAFE_F00D, 4'hF);
    a_read(9'd383, rd, err, lat);
    check_eq("a_rd383", {rd, err}, {32'hCAFE_F00D, 1'b0});

    // Same-cycle A write / B read of address 7
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'd7; a_req_wdata = 32'h1122_3344; a_req_wmask = 4'hF;
    b_req_valid = 1'b1; b_req_addr = 9'd7;
    #1;
    check_eq("same_ready", {a_req_ready, b_req_ready}, 2'b11);
    @(posedge clk); #1;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check_eq("same_lat", 64'(lat), 64'd2);
`ifdef SRAM_CTRL_WR_FWD_EN
    check_eq("same_b_data", 64'(b_rsp_rdata), 64'h1122_3344);
`else
    check_eq("same_b_data", 64'(b_rsp_rdata), 64'h0);
`endif
    a_read(9'd7, rd, err, lat);
    check_eq("a_rd7", 64'(rd), 64'h1122_3344);
    check_eq("init_done_held", 64'(init_done), 64'd1);

    // Reset mid-fill at counter 100
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin @(posedge clk); #1; end
    check_eq("mid_addr100", 64'(sram_rw0_addr), 64'd100);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_eq("mid_rst_state", {init_done, sram_rw0_ce, a_req_ready}, 3'b000);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_eq("mid_restart_addr", 64'(sram_rw0_addr), 64'd0);
    wait_init(n);
    check_eq("mid_init_cycles", 64'(n), 64'd384);
    b_read(9'd5, rd, err, lat);
    check_eq("refill_rd5", {rd, err}, {32'h0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/liteeth_sram_ctrl.md
Name: liteeth_sram_ctrl

Overview:
Initiator-side controller for the 1rw1r 32-bit x 384-word byte-masked SRAM macro used in liteeth buffers. It converts two valid/ready request channels into macro port signals: channel A (read/write) drives rw0 and channel B (read-only) drives r0. It returns read data through per-channel response buffers that tolerate backpressure. After reset it zero-fills the array before opening either channel.

Parameters:
BITS, 32, data width; must be a multiple of 8
WORD_DEPTH, 384, number of valid words
ADDR_WIDTH, 9, address width
MASK_WIDTH, BITS/8, byte-mask width
RSP_DEPTH, 2, response buffer entries per channel

Ports:
clk  in  1  single clock; also drives the macro's r0_clk and rw0_clk
rst_n  in  1  asynchronous active-low reset
a_req_valid / a_req_ready  in/out  1  channel A request handshake
a_req_we  in  1  1 = write, 0 = read
a_req_addr  in  ADDR_WIDTH  word address
a_req_wdata  in  BITS  write data
a_req_wmask  in  MASK_WIDTH  byte enables
a_rsp_valid / a_rsp_ready  out/in  1  channel A read-response handshake
a_rsp_rdata  out  BITS  read data
a_rsp_err  out  1  address was out of range
b_req_valid / b_req_ready  in/out  1  channel B request handshake
b_req_addr  in  ADDR_WIDTH  read address
b_rsp_valid / b_rsp_ready  out/in  1  channel B response handshake
b_rsp_rdata  out  BITS  read data
b_rsp_err  out  1  address was out of range
sram_rw0_ce, sram_rw0_we  out  1  macro rw0 chip enable and write enable
sram_rw0_addr  out  ADDR_WIDTH  macro rw0 address
sram_rw0_wd  out  BITS  macro rw0 write data
sram_rw0_wmask  out  MASK_WIDTH  macro rw0 byte mask
sram_rw0_rd  in  BITS  macro rw0 read data
sram_r0_ce  out  1  macro r0 chip enable
sram_r0_addr  out  ADDR_WIDTH  macro r0 address
sram_r0_rd  in  BITS  macro r0 read data
init_done  out  1  high once zero-fill is complete

Behaviour:
- Reset values: all ready/valid outputs 0, init_done 0, sram_* enables 0, rsp_rdata 0, rsp_err 0, init counter 0, FSM in INIT.
- FSM states: INIT, RUN.
- INIT, one word per cycle:
  - Drive rw0_ce=1, we=1, wmask all ones, wd=0, addr=counter.
  - Transition to RUN after writing address WORD_DEPTH-1, i.e. after exactly 384 write cycles.
  - Both req_ready outputs are 0 throughout INIT.
  - Assertion of rst_n mid-INIT restarts the fill from address 0.
- RUN:
  - init_done=1 permanently until the next reset.
  - The SRAM port outputs are combinational from the accepted request.
  - A transaction fires on req_valid & req_ready; ce=1 only in that cycle, otherwise ce=0 and we=0.
- Read latency:
  - A read accepted in cycle T has macro data valid in T+1.
  - That data is captured into the response buffer at the end of T+1.
  - rsp_valid is high from T+2.
  - Responses are returned in request order per channel.
- Credit rule per channel: req_ready = (inflight + buffer occupancy) < RSP_DEPTH.
  - Writes need no credit; A is ready for a write whenever it is in RUN.
  - A read and a rsp pop in the same cycle are both allowed; the count is updated net.
  - This sustains 1 read per cycle when rsp_ready is held high.
- Writes produce no response.
- Out-of-range address (addr >= WORD_DEPTH):
  - The request is accepted and ce stays 0.
  - A read pushes {rdata=0, err=1} on the normal latency schedule.
  - A write is dropped silently.
- Macro outputs are X when ce=0; the controller never samples rd in a cycle not following its own ce.
- Same-cycle A write and B read to the same address: B returns the old word (read-first), unless the option below is enabled.
- Response buffer full with rsp_ready=0: req_ready stays 0; there is no overflow by construction.

Optional Feature:
SRAM_CTRL_WR_FWD_EN
- Defined: a B read that coincides with an A write to the same in-range address returns the merged word. Masked bytes come from a_req_wdata; the other bytes come from the macro. This adds one BITS-wide forward register.
- Undefined: strict read-first old data.

Decomposition:
- Package liteeth_sram_pkg holds:
  - constants WORD_DEPTH, ADDR_WIDTH, BITS, MASK_WIDTH;
  - enum ctrl_state_e {INIT, RUN};
  - typedef rsp_t {logic [BITS-1:0] rdata; logic err;}.
- Sub-module liteeth_sram_rsp_buf holds one per-channel response buffer and its credit counter. It is instantiated twice.

Test Plan:
- Reset, then idle -> init_done rises exactly 384 cycles after rst_n deasserts; B reads of addresses 0, 200 and 383 return 0x00000000.
- A writes 0xDEADBEEF to address 5 with wmask=4'b0101, then A reads address 5 -> response 0x00AD00EF, err=0, arriving 2 cycles after acceptance.
- B issues back-to-back reads of addresses 1..4 with rsp_ready held 0 -> exactly 2 accepted, b_req_ready=0; raise rsp_ready -> 4 responses in order with no loss or duplication.
- A reads address 400 -> rsp_err=1 and rdata=0, sram_rw0_ce never high; A writes address 383 succeeds, and a readback matches.
- Same cycle: A writes 0x11223344 to address 7 (full mask, old value 0) while B reads address 7 -> B gets 0x00000000 without SRAM_CTRL_WR_FWD_EN, and 0x11223344 with it.
- Pulse rst_n low at init counter 100 -> the fill restarts from address 0; init_done rises 384 cycles after release.
